// File: rtl/dmem_arbiter.sv
// Purpose : round-robin arbiter sharing one data-memory port between N_CORES cores.
// Latency : MEM_LAT+3 cycles per transaction (grant, access, MEM_LAT wait, done).
// Backpressure: losing and in-flight cores see core_stall until their done pulse.
// Ports:
//   Clk / Reset           clock, asynchronous active-high reset
//   core_req/we/half/byte per-core request and attributes (one bit per core)
//   core_addr/core_wdata  per-core address / store data, packed by core index
//   core_stall/core_done  per-core freeze and one-cycle completion pulse
//   core_rdata            shared registered load data, valid with core_done
//   mem_*                 single memory port (strobe, latched attributes, data)
//   busy / grant_id       arbiter occupied / core currently (or last) served
module dmem_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [N_CORES-1:0]         core_req,
  input  logic [N_CORES-1:0]         core_we,
  input  logic [N_CORES-1:0]         core_half,
  input  logic [N_CORES-1:0]         core_byte,
  input  logic [N_CORES*ADDR_W-1:0]  core_addr,
  input  logic [N_CORES*DATA_W-1:0]  core_wdata,
  output logic [N_CORES-1:0]         core_stall,
  output logic [N_CORES-1:0]         core_done,
  output logic [DATA_W-1:0]          core_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic                       mem_half,
  output logic                       mem_byte,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy,
  output logic [2:0]                 grant_id
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         grant_q, grant_d;
  logic [N_CORES-1:0] done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_half_q, mem_half_d;
  logic               mem_byte_q, mem_byte_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  // Arbitration scratch
  logic [7:0]         req_pad;
  logic [3:0]         arb_sum;
  logic               found;
  logic [2:0]         pick;

  // Attributes of the picked core
  logic               sel_we, sel_half, sel_byte;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Round-robin search: first requester at or above ptr, wrapping modulo N_CORES.
  // Padding the request vector to 8 bits keeps the 3-bit index in range.
  always_comb begin
    req_pad                = '0;
    req_pad[N_CORES-1:0]   = core_req;
    arb_sum                = '0;
    found                  = 1'b0;
    pick                   = '0;
    for (int k = 0; k < N_CORES; k++) begin
      arb_sum = {1'b0, ptr_q} + 4'(k);
      if (arb_sum >= 4'(N_CORES)) begin
        arb_sum = arb_sum - 4'(N_CORES);
      end
      if (!found && req_pad[arb_sum[2:0]]) begin
        found = 1'b1;
        pick  = arb_sum[2:0];
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_half  = 1'b0;
    sel_byte  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (pick == 3'(i)) begin
        sel_we    = core_we[i];
        sel_half  = core_half[i];
        sel_byte  = core_byte[i];
        sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    done_d      = '0;
    rdata_d     = rdata_q;
    mem_we_d    = mem_we_q;
    mem_half_d  = mem_half_q;
    mem_byte_d  = mem_byte_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        // Request fields are sampled here only; later input changes are ignored.
        if (found) begin
          grant_d     = pick;
          mem_we_d    = sel_we;
          mem_half_d  = sel_half;
          mem_byte_d  = sel_byte;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d   = 3'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          // Captured for stores too; the value is simply unused then.
          rdata_d = mem_rdata;
          state_d = S_DONE;
          // done is registered so it is high exactly during the DONE cycle.
          for (int i = 0; i < N_CORES; i++) begin
            done_d[i] = (grant_q == 3'(i));
          end
        end
      end
      S_DONE: begin
        ptr_d   = (grant_q == 3'(N_CORES-1)) ? 3'd0 : grant_q + 3'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_half_q  <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_we_q    <= mem_we_d;
      mem_half_q  <= mem_half_d;
      mem_byte_q  <= mem_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Decoded straight from the state register so an asynchronous reset
  // drops the strobe and busy immediately.
  assign mem_en     = (state_q == S_ACCESS);
  assign busy       = (state_q != S_IDLE);
  assign core_stall = core_req & ~done_q;
  assign core_done  = done_q;
  assign core_rdata = rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_half   = mem_half_q;
  assign mem_byte   = mem_byte_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Instance with MEM_LAT=1 (u1) and MEM_LAT=3 (u3), each with its own inputs.
  logic [3:0]   req1 = '0, we1 = '0, half1 = '0, byte1 = '0;
  logic [127:0] addr1 = '0, wdata1 = '0;
  logic [3:0]   stall1, done1;
  logic [31:0]  rdata1, maddr1, mwdata1, mrdata1;
  logic         men1, mwe1, mhalf1, mbyte1, busy1;
  logic [2:0]   gid1;

  logic [3:0]   req3 = '0, we3 = '0, half3 = '0, byte3 = '0;
  logic [127:0] addr3 = '0, wdata3 = '0;
  logic [3:0]   stall3, done3;
  logic [31:0]  rdata3, maddr3, mwdata3, mrdata3;
  logic         men3, mwe3, mhalf3, mbyte3, busy3;
  logic [2:0]   gid3;

  dmem_arbiter #(.N_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .Clk(Clk), .Reset(Reset),
    .core_req(req1), .core_we(we1), .core_half(half1), .core_byte(byte1),
    .core_addr(addr1), .core_wdata(wdata1),
    .core_stall(stall1), .core_done(done1), .core_rdata(rdata1),
    .mem_en(men1), .mem_we(mwe1), .mem_half(mhalf1), .mem_byte(mbyte1),
    .mem_addr(maddr1), .mem_wdata(mwdata1), .mem_rdata(mrdata1),
    .busy(busy1), .grant_id(gid1)
  );

  dmem_arbiter #(.N_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u3 (
    .Clk(Clk), .Reset(Reset),
    .core_req(req3), .core_we(we3), .core_half(half3), .core_byte(byte3),
    .core_addr(addr3), .core_wdata(wdata3),
    .core_stall(stall3), .core_done(done3), .core_rdata(rdata3),
    .mem_en(men3), .mem_we(mwe3), .mem_half(mhalf3), .mem_byte(mbyte3),
    .mem_addr(maddr3), .mem_wdata(mwdata3), .mem_rdata(mrdata3),
    .busy(busy3), .grant_id(gid3)
  );

  // Memory models: data is valid only in the exact cycle MEM_LAT after mem_en.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  logic       pipe1 = 1'b0;
  logic [2:0] pipe3 = 3'b000;
  always @(posedge Clk) begin
    pipe1 <= men1;
    pipe3 <= {pipe3[1:0], men3};
  end
  assign mrdata1 = pipe1    ? memfn(maddr1) : 32'h0BAD0BAD;
  assign mrdata3 = pipe3[2] ? memfn(maddr3) : 32'h0BAD0BAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc;
    @(posedge Clk);
    #1;
  endtask

  int          men_cnt;
  logic [3:0]  pend;
  logic [31:0] gexp;

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("rst_busy",   {31'b0, busy1}, 32'd0);
    chk("rst_men",    {31'b0, men1},  32'd0);
    chk("rst_done",   {28'b0, done1}, 32'd0);
    chk("rst_gid",    {29'b0, gid1},  32'd0);
    chk("rst_rdata",  rdata1,         32'd0);
    chk("rst_maddr",  maddr1,         32'd0);
    chk("rst_mwe",    {31'b0, mwe1},  32'd0);
    cyc();
    Reset = 1'b0;

    // ---------------- single load, core 2 ----------------
    cyc();                                   // T
    req1 = 4'b0100; addr1[2*32 +: 32] = 32'h40;
    #1;
    chk("ld_stall_T", {28'b0, stall1}, 32'h4);
    cyc();                                   // T+1
    chk("ld_men",   {31'b0, men1},  32'd1);
    chk("ld_maddr", maddr1,         32'h40);
    chk("ld_mwe",   {31'b0, mwe1},  32'd0);
    chk("ld_gid",   {29'b0, gid1},  32'd2);
    chk("ld_busy",  {31'b0, busy1}, 32'd1);
    chk("ld_stall_T1", {28'b0, stall1}, 32'h4);
    cyc();                                   // T+2
    chk("ld_men_T2", {31'b0, men1}, 32'd0);
    chk("ld_stall_T2", {28'b0, stall1}, 32'h4);
    chk("ld_done_T2", {28'b0, done1}, 32'h0);
    cyc();                                   // T+3
    chk("ld_done",  {28'b0, done1}, 32'h4);
    chk("ld_rdata", rdata1,         32'hDEADBEEF);
    chk("ld_stall_T3", {28'b0, stall1}, 32'h0);
    req1 = 4'b0000;
    cyc();                                   // T+4
    chk("ld_done_T4", {28'b0, done1}, 32'h0);
    chk("ld_idle",    {31'b0, busy1}, 32'd0);

    // ---------------- four-way contention from reset ----------------
    Reset = 1'b1; #1; Reset = 1'b0;
    cyc();                                   // T
    for (int i = 0; i < 4; i++) addr1[i*32 +: 32] = 32'h100 + 32'(4*i);
    req1 = 4'b1111;
    pend = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cyc();                                 // T+4k+1
      chk($sformatf("c4_gid%0d", k),   {29'b0, gid1}, 32'(k));
      chk($sformatf("c4_men%0d", k),   {31'b0, men1}, 32'd1);
      chk($sformatf("c4_maddr%0d", k), maddr1, 32'h100 + 32'(4*k));
      chk($sformatf("c4_stall%0d", k), {28'b0, stall1}, {28'b0, pend});
      cyc(); cyc();                          // T+4k+3
      chk($sformatf("c4_done%0d", k),  {28'b0, done1}, 32'(1 << k));
      chk($sformatf("c4_rdata%0d", k), rdata1, memfn(32'h100 + 32'(4*k)));
      pend[k] = 1'b0;
      chk($sformatf("c4_stalld%0d", k), {28'b0, stall1}, {28'b0, pend});
      req1 = pend;
      cyc();                                 // T+4k+4
      chk($sformatf("c4_idle%0d", k), {31'b0, busy1}, 32'd0);
    end

    // ---------------- fairness: core 0 always, core 1 from cycle 2 ----------------
    Reset = 1'b1; #1; Reset = 1'b0;
    cyc();                                   // cycle 0
    req1 = 4'b0001;
    for (int c = 1; c <= 15; c++) begin
      cyc();
      if (c == 2) req1 = 4'b0011;
      gexp = ((c / 4) % 2 == 0) ? 32'd0 : 32'd1;
      if (c % 4 == 1) begin
        chk($sformatf("fair_gid_c%0d", c), {29'b0, gid1}, gexp);
        chk($sformatf("fair_men_c%0d", c), {31'b0, men1}, 32'd1);
      end
      if (c % 4 == 3) begin
        chk($sformatf("fair_done_c%0d", c), {28'b0, done1}, 32'(1 << gexp));
      end
    end
    req1 = 4'b0000;
    cyc();
    chk("fair_idle", {31'b0, busy1}, 32'd0);

    // ---------------- long latency store halfword, core 1 ----------------
    cyc();                                   // T
    req3 = 4'b0010; we3 = 4'b0010; half3 = 4'b0010;
    addr3[1*32 +: 32] = 32'h102; wdata3[1*32 +: 32] = 32'h1234;
    men_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (men3) men_cnt++;
      if (c == 1) begin
        chk("st_mwe",    {31'b0, mwe3},   32'd1);
        chk("st_mhalf",  {31'b0, mhalf3}, 32'd1);
        chk("st_mbyte",  {31'b0, mbyte3}, 32'd0);
        chk("st_maddr",  maddr3,          32'h102);
        chk("st_mwdata", mwdata3,         32'h1234);
      end
      if (c < 5) chk($sformatf("st_nodone_c%0d", c), {28'b0, done3}, 32'h0);
      else       chk("st_done", {28'b0, done3}, 32'h2);
    end
    chk("st_men_cycles", 32'(men_cnt), 32'd1);
    req3 = 4'b0000; we3 = 4'b0000; half3 = 4'b0000;
    cyc();

    // ---------------- reset mid-WAIT, core 2 load ----------------
    cyc();                                   // T
    req3 = 4'b0100; addr3[2*32 +: 32] = 32'h200;
    cyc();                                   // T+1 ACCESS
    chk("rw_men_acc", {31'b0, men3}, 32'd1);
    cyc();                                   // T+2 WAIT
    chk("rw_busy_wait", {31'b0, busy3}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("rw_busy_rst",  {31'b0, busy3}, 32'd0);
    chk("rw_men_rst",   {31'b0, men3},  32'd0);
    chk("rw_maddr_rst", maddr3,         32'd0);
    cyc();                                   // T+3, reset still high
    chk("rw_done_rst", {28'b0, done3}, 32'h0);
    Reset = 1'b0;                            // R: IDLE sees pending request
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 1) begin
        chk("rw_regrant_men", {31'b0, men3}, 32'd1);
        chk("rw_regrant_gid", {29'b0, gid3}, 32'd2);
        chk("rw_regrant_addr", maddr3, 32'h200);
      end
      if (c < 5) chk($sformatf("rw_nodone_c%0d", c), {28'b0, done3}, 32'h0);
      else begin
        chk("rw_done",  {28'b0, done3}, 32'h4);
        chk("rw_rdata", rdata3, memfn(32'h200));
      end
    end
    req3 = 4'b0000;
    cyc();

    // ---------------- request change after grant, core 3 ----------------
    cyc();                                   // T
    req1 = 4'b1000; addr1[3*32 +: 32] = 32'h10;
    half1 = 4'b1000; byte1 = 4'b1000;
    cyc();                                   // T+1 ACCESS
    addr1[3*32 +: 32] = 32'h20; half1 = 4'b0000; byte1 = 4'b0000;
    #1;
    chk("chg_maddr_acc", maddr1, 32'h10);
    chk("chg_gid",       {29'b0, gid1},   32'd3);
    chk("chg_mhalf",     {31'b0, mhalf1}, 32'd1);
    chk("chg_mbyte",     {31'b0, mbyte1}, 32'd1);
    cyc();                                   // T+2
    chk("chg_maddr_wait", maddr1, 32'h10);
    cyc();                                   // T+3
    chk("chg_done",  {28'b0, done1}, 32'h8);
    chk("chg_rdata", rdata1, memfn(32'h10));
    req1 = 4'b0000;
    cyc();
    chk("chg_gid_hold", {29'b0, gid1}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
